// File: rtl/mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_pkg
//   Shared definitions for the multiply/divide sequencer:
//   - MD_* operation codes (4-bit) presented on the op bus by the E stage
//   - default busy-cycle counts for multiply and divide
//   - FSM state encoding
//   - helper that classifies an op as a multi-cycle (mult/div) operation
// -----------------------------------------------------------------------------
package mdu_ctrl_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [3:0] op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// mdu_ctrl_if
//   Bus between the E/D pipeline stages and the multiply/divide sequencer.
//   master : pipeline side (drives start/op/operands/D_md, reads status/HI/LO)
//   slave  : mdu_ctrl side
//   Signals:
//     start   1   E-stage instruction is an md op this cycle
//     op      4   MD_* operation code
//     rs_val  32  forwarded rs operand
//     rt_val  32  forwarded rt operand
//     D_md    1   D-stage instruction is md-class (md op, mfhi, mflo)
//     busy    1   multi-cycle op in flight
//     stall   1   D-stage stall request
//     hi, lo  32  architectural HI/LO registers
// -----------------------------------------------------------------------------
interface mdu_ctrl_if;

    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        D_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, D_md,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, D_md,
        output busy, stall, hi, lo
    );

endinterface

// File: rtl/mdu_ctrl_md_calc.sv
// -----------------------------------------------------------------------------
// md_calc
//   Purely combinational result generator for the multiply/divide unit.
//   Ports:
//     op        in   4   MD_* operation code
//     rs_val    in   32  first operand (multiplicand / dividend)
//     rt_val    in   32  second operand (multiplier / divisor)
//     res_hi    out  32  product[63:32] or remainder
//     res_lo    out  32  product[31:0]  or quotient
//     div_zero  out  1   divide op with a zero divisor (result must not commit)
//   Non mult/div ops give zero results.
// -----------------------------------------------------------------------------
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        is_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;
    logic        neg_a_s;
    logic        neg_b_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] divisor_s;
    logic [31:0] quot_u_s;
    logic [31:0] rem_u_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Operand conditioning and raw arithmetic for both multiply and divide.
    always_comb begin
        is_signed_s = (op == MD_MULT) || (op == MD_DIV);

        // Sign/zero extend to 64 bits; the low 64 bits of the product are then
        // correct for both signed and unsigned interpretations.
        mul_a_s = is_signed_s ? {{32{rs_val[31]}}, rs_val} : {32'd0, rs_val};
        mul_b_s = is_signed_s ? {{32{rt_val[31]}}, rt_val} : {32'd0, rt_val};
        prod_s  = mul_a_s * mul_b_s;

        // Signed divide is done on magnitudes, then sign-corrected. This keeps
        // the most-negative / -1 case well defined (quotient wraps to itself).
        neg_a_s   = is_signed_s & rs_val[31];
        neg_b_s   = is_signed_s & rt_val[31];
        abs_a_s   = neg_a_s ? (32'd0 - rs_val) : rs_val;
        abs_b_s   = neg_b_s ? (32'd0 - rt_val) : rt_val;
        // A zero divisor is replaced so the divider never sees it; the result
        // is discarded by the sequencer anyway.
        divisor_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
        quot_u_s  = abs_a_s / divisor_s;
        rem_u_s   = abs_a_s % divisor_s;
        // Truncation toward zero: quotient negative when signs differ,
        // remainder follows the dividend.
        quot_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - quot_u_s) : quot_u_s;
        rem_s     = neg_a_s ? (32'd0 - rem_u_s) : rem_u_s;
    end

    // Result selection by operation.
    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi   = rem_s;
                res_lo   = quot_s;
                div_zero = (rt_val == 32'd0);
            end
            default: begin
                res_hi   = 32'd0;
                res_lo   = 32'd0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Sequencer for the multiply/divide resource beside the E-stage ALU. Holds
//   the HI/LO architectural registers, models the fixed mult/div latency with
//   a down-counter and raises the D-stage stall for md-class instructions
//   while the unit is occupied.
//   Ports:
//     clk    in   single clock, all state on posedge
//     reset  in   synchronous, active-high; discards any in-flight result
//     bus    slave side of mdu_ctrl_if (start/op/rs_val/rt_val/D_md in,
//            busy/stall/hi/lo out)
//   Parameters:
//     MULT_CYCLES  busy cycles after a mult/multu start (>=1)
//     DIV_CYCLES   busy cycles after a div/divu start (>=1, >= MULT_CYCLES)
// -----------------------------------------------------------------------------
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    localparam int              CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_nx_q, hi_nx_d;
    logic [31:0]      lo_nx_q, lo_nx_d;
    logic             commit_q, commit_d;

    logic [31:0]      calc_hi_s;
    logic [31:0]      calc_lo_s;
    logic             calc_div_zero_s;
    logic             busy_s;

    md_calc u_calc (
        .op       (bus.op),
        .rs_val   (bus.rs_val),
        .rt_val   (bus.rt_val),
        .res_hi   (calc_hi_s),
        .res_lo   (calc_lo_s),
        .div_zero (calc_div_zero_s)
    );

    // Next-state logic: op acceptance in IDLE, countdown and commit in BUSY.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nx_d  = hi_nx_q;
        lo_nx_d  = lo_nx_q;
        commit_d = commit_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MD_MULT, MD_MULTU: begin
                            hi_nx_d  = calc_hi_s;
                            lo_nx_d  = calc_lo_s;
                            commit_d = 1'b1;
                            cnt_d    = MULT_LOAD;
                            state_d  = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            hi_nx_d  = calc_hi_s;
                            lo_nx_d  = calc_lo_s;
                            // Divide by zero still runs the full busy
                            // sequence but leaves HI/LO untouched.
                            commit_d = ~calc_div_zero_s;
                            cnt_d    = DIV_LOAD;
                            state_d  = ST_BUSY;
                        end
                        MD_MTHI: begin
                            hi_d = bus.rs_val;
                        end
                        MD_MTLO: begin
                            lo_d = bus.rs_val;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // New starts are ignored here; the hazard unit holds them off.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (commit_q) begin
                        hi_d = hi_nx_q;
                        lo_d = lo_nx_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset clears everything including the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_nx_q  <= 32'd0;
            lo_nx_q  <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nx_q  <= hi_nx_d;
            lo_nx_q  <= lo_nx_d;
            commit_q <= commit_d;
        end
    end

    assign busy_s = (state_q == ST_BUSY);

    // The stall also covers the issue cycle of a long op so the md-class
    // instruction in D waits behind an op that is only just entering the unit.
    assign bus.stall = bus.D_md & (busy_s | (bus.start & is_long_op(bus.op)));
    assign bus.busy  = busy_s;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
